// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding instruction-memory request, an IF/ID register,
// a one-entry hold buffer for responses that arrive while decode is stalled, and redirect flushing.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_pcsrc,
    input  logic [31:0] io_target,
    input  logic        io_stall,
    output logic        io_imem_req,
    output logic [31:0] io_imem_addr,
    input  logic        io_imem_ready,
    input  logic        io_imem_rvalid,
    input  logic [31:0] io_imem_rdata,
    output logic        io_id_valid,
    output logic [31:0] io_id_pc,
    output logic [31:0] io_id_inst,
    output logic [31:0] io_id_pcplus4
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        hold_vld;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;

    logic accept;
    logic resp;
    logic advance;

    // A redirect suppresses the request combinationally so the stale pc never reaches memory.
    assign io_imem_req   = (state == FETCH) && !hold_vld && !io_pcsrc && reset;
    assign io_imem_addr  = pc;
    assign accept        = io_imem_req && io_imem_ready;
    assign resp          = (state == WAIT) && io_imem_rvalid && !io_pcsrc;
    assign advance       = !io_stall || !io_id_valid;
    assign io_id_pcplus4 = io_id_pc + 32'd4;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc          <= RESET_PC;
            state       <= FETCH;
            hold_vld    <= 1'b0;
            io_id_valid <= 1'b0;
            io_id_pc    <= 32'd0;
            io_id_inst  <= NOP_INST;
        end else begin
            case (state)
                FETCH: begin
                    if (accept) state <= WAIT;
                end
                WAIT: begin
                    if (io_imem_rvalid)  state <= FETCH;
                    else if (io_pcsrc)   state <= DISCARD;
                end
                DISCARD: begin
                    // The response still owed for the abandoned request closes the discard window.
                    if (io_imem_rvalid) state <= FETCH;
                end
                default: state <= FETCH;
            endcase

            if (io_pcsrc) begin
                pc          <= io_target;
                hold_vld    <= 1'b0;
                io_id_valid <= 1'b0;
                io_id_inst  <= NOP_INST;
            end else begin
                if (accept) pc <= pc + 32'd4;
                if (advance) begin
                    if (hold_vld) begin
                        io_id_valid <= 1'b1;
                        io_id_pc    <= hold_pc;
                        io_id_inst  <= hold_inst;
                        hold_vld    <= 1'b0;
                    end else if (resp) begin
                        io_id_valid <= 1'b1;
                        io_id_pc    <= req_pc;
                        io_id_inst  <= io_imem_rdata;
                    end else begin
                        io_id_valid <= 1'b0;
                        io_id_inst  <= NOP_INST;
                    end
                end else if (resp) begin
                    hold_vld <= 1'b1;
                end
            end
        end
    end

    // Address and hold-buffer payload are qualified by state/hold_vld, so they need no reset.
    always_ff @(posedge clock) begin
        if (accept) req_pc <= pc;
        if (resp && !advance) begin
            hold_pc   <= req_pc;
            hold_inst <= io_imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against an
// in-order instruction-stream reference model and a single-outstanding memory responder.
module tb_fetch_stage;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        pcsrc, stall;
    logic [31:0] target;
    logic        req, ready, rvalid;
    logic [31:0] addr, rdata;
    logic        id_valid;
    logic [31:0] id_pc, id_inst, id_pcplus4;

    logic        w_req, w_rvalid, w_id_valid;
    logic [31:0] w_addr, w_rdata, w_id_pc, w_id_inst, w_id_pcplus4;

    fetch_stage dut (
        .clock(clk), .reset(rst_n), .io_pcsrc(pcsrc), .io_target(target), .io_stall(stall),
        .io_imem_req(req), .io_imem_addr(addr), .io_imem_ready(ready),
        .io_imem_rvalid(rvalid), .io_imem_rdata(rdata),
        .io_id_valid(id_valid), .io_id_pc(id_pc), .io_id_inst(id_inst), .io_id_pcplus4(id_pcplus4)
    );

    fetch_stage #(.RESET_PC(WRAP_PC)) u_wrap (
        .clock(clk), .reset(rst_n), .io_pcsrc(1'b0), .io_target(32'd0), .io_stall(1'b0),
        .io_imem_req(w_req), .io_imem_addr(w_addr), .io_imem_ready(1'b1),
        .io_imem_rvalid(w_rvalid), .io_imem_rdata(w_rdata),
        .io_id_valid(w_id_valid), .io_id_pc(w_id_pc), .io_id_inst(w_id_inst),
        .io_id_pcplus4(w_id_pcplus4)
    );

    int checks;
    int errors;

    typedef enum logic [2:0] {K_NONE, K_RST, K_FLUSH, K_HOLD, K_ADV} kind_e;
    kind_e       kind;
    logic [31:0] fetch_pc;   // address the next request must carry
    logic [31:0] exp_pc;     // pc of the next instruction that must reach decode
    logic [31:0] held_pc, held_inst;
    int          n_deliv;
    logic [31:0] last_pc;

    logic        pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          ready_mode;
    int          delay_lo, delay_hi;
    logic        w_pend;
    logic [31:0] w_pend_addr;

    logic        rnd_stim;
    logic        live_chk;
    int          idle;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Observation point, half a cycle after the edge: judge what the last edge produced.
    task automatic begin_cycle();
        @(negedge clk);
        chk("pcplus4", id_pcplus4, id_pc + 32'd4);
        case (kind)
            K_RST: begin
                chk("rst_valid", 32'(id_valid), 32'd0);
                chk("rst_pc", id_pc, 32'd0);
                chk("rst_inst", id_inst, NOP);
                chk("rst_pcplus4", id_pcplus4, 32'd4);
            end
            K_FLUSH: begin
                chk("flush_valid", 32'(id_valid), 32'd0);
                chk("flush_inst", id_inst, NOP);
            end
            K_HOLD: begin
                chk("hold_valid", 32'(id_valid), 32'd1);
                chk("hold_pc", id_pc, held_pc);
                chk("hold_inst", id_inst, held_inst);
            end
            K_ADV: begin
                if (id_valid) begin
                    chk("deliv_pc", id_pc, exp_pc);
                    chk("deliv_inst", id_inst, mem_word(exp_pc));
                    exp_pc  = exp_pc + 32'd4;
                    n_deliv++;
                    last_pc = id_pc;
                    idle    = 0;
                end else begin
                    chk("bubble_inst", id_inst, NOP);
                end
            end
            default: ;
        endcase
        if (live_chk) begin
            idle++;
            checks++;
            assert (idle < 100) else begin
                errors++;
                $error("FAIL liveness idle_cycles=%0d limit=100", idle);
                idle = 0;
            end
        end
    endtask

    // Drive this cycle's memory/stimulus, then advance the reference model across the edge.
    task automatic end_cycle();
        logic accept;
        if (rnd_stim) begin
            stall  = ($urandom_range(99, 0) < 30);
            pcsrc  = ($urandom_range(99, 0) < 4);
            target = 32'($urandom_range(1023, 0)) << 2;
        end
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ($urandom_range(99, 0) < 70);
            default: ready = 1'b0;
        endcase
        if (!rst_n) begin
            rvalid = 1'($urandom_range(1, 0));
            rdata  = $urandom;
        end else if (pend && pend_wait == 0) begin
            rvalid = 1'b1;
            rdata  = mem_word(pend_addr);
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
        end
        w_rvalid = w_pend && rst_n;
        w_rdata  = mem_word(w_pend_addr);
        #1;
        accept = req && ready;
        if (!rst_n) begin
            chk("req_in_reset", 32'(req), 32'd0);
            kind     = K_RST;
            fetch_pc = 32'd0;
            exp_pc   = 32'd0;
            pend     = 1'b0;
            w_pend   = 1'b0;
        end else begin
            if (req)   chk("req_addr", addr, fetch_pc);
            if (pcsrc) chk("req_on_redirect", 32'(req), 32'd0);
            if (rvalid)    pend = 1'b0;
            else if (pend) pend_wait--;
            if (accept) begin
                checks++;
                assert (!pend) else begin
                    errors++;
                    $error("FAIL outstanding observed=2 expected=1");
                end
                pend      = 1'b1;
                pend_addr = addr;
                pend_wait = int'($urandom_range(delay_hi, delay_lo)) - 1;
            end
            if (pcsrc) begin
                fetch_pc = target;
                exp_pc   = target;
                kind     = K_FLUSH;
            end else begin
                if (accept) fetch_pc = fetch_pc + 32'd4;
                if (stall && id_valid) begin
                    kind      = K_HOLD;
                    held_pc   = id_pc;
                    held_inst = id_inst;
                end else begin
                    kind = K_ADV;
                end
            end
            w_pend      = w_req;
            w_pend_addr = w_addr;
        end
    endtask

    task automatic step();
        end_cycle();
        begin_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulated_time=%0t limit=1000000", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic        found;
        logic [31:0] a_held;
        checks = 0; errors = 0; kind = K_NONE; n_deliv = 0; last_pc = 0; idle = 0;
        rnd_stim = 1'b0; live_chk = 1'b0; ready_mode = 0; delay_lo = 1; delay_hi = 1;
        pend = 1'b0; pend_addr = 0; pend_wait = 0; w_pend = 1'b0; w_pend_addr = 0;
        fetch_pc = 0; exp_pc = 0; held_pc = 0; held_inst = 0;
        rst_n = 1'b0; stall = 1'b0; pcsrc = 1'b0; target = 0;
        ready = 1'b1; rvalid = 1'b0; rdata = 0; w_rvalid = 1'b0; w_rdata = 0;

        // Reset, then straight-line fetch with single-cycle memory.
        begin_cycle();
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        chk("c0_req", 32'(req), 32'd1);
        chk("c0_addr", addr, 32'd0);
        chk("wrap_c0_addr", w_addr, WRAP_PC);
        step();
        chk("c1_req_wait", 32'(req), 32'd0);
        chk("c1_valid", 32'(id_valid), 32'd0);
        step();
        chk("first_valid", 32'(id_valid), 32'd1);
        chk("first_pc", id_pc, 32'd0);
        chk("first_inst", id_inst, mem_word(32'd0));
        chk("c2_addr", addr, 32'd4);
        chk("wrap_pc", w_id_pc, WRAP_PC);
        chk("wrap_pcplus4", w_id_pcplus4, 32'd0);
        chk("wrap_inst", w_id_inst, mem_word(WRAP_PC));
        chk("wrap_next_req", 32'(w_req), 32'd1);
        chk("wrap_next_addr", w_addr, 32'd0);
        repeat (4) step();
        chk("line_count", 32'(n_deliv), 32'd3);
        chk("line_last_pc", last_pc, 32'd8);

        // Stall with a response arriving: it must park and later drain in order.
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = id_valid && (id_pc == 32'd4);
        end
        chk("stall_reach_pc4", 32'(found), 32'd1);
        stall = 1'b1;
        step();
        chk("stall_pc_a", id_pc, 32'd4);
        step();
        chk("stall_pc_b", id_pc, 32'd4);
        chk("stall_noreq_b", 32'(req), 32'd0);
        step();
        chk("stall_pc_c", id_pc, 32'd4);
        chk("stall_noreq_c", 32'(req), 32'd0);
        stall = 1'b0;
        step();
        chk("drain_valid", 32'(id_valid), 32'd1);
        chk("drain_pc", id_pc, 32'd8);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = id_valid;
        end
        chk("after_drain_found", 32'(found), 32'd1);
        chk("after_drain_pc", id_pc, 32'd12);

        // Backpressure: request and address hold until the memory accepts.
        ready_mode = 2;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = req;
        end
        chk("bp_req_seen", 32'(found), 32'd1);
        a_held = addr;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_req_held", 32'(req), 32'd1);
            chk("bp_addr_held", addr, a_held);
        end
        ready_mode = 0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            found = req;
        end
        chk("bp_next_req", 32'(found), 32'd1);
        chk("bp_next_addr", addr, a_held + 32'd4);

        // Redirect while waiting: late response dropped, next fetch at the target.
        delay_lo = 3; delay_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = req;
        end
        chk("rdw_req_seen", 32'(found), 32'd1);
        step();
        pcsrc = 1'b1; target = 32'h100;
        step();
        chk("rdw_flush_valid", 32'(id_valid), 32'd0);
        chk("rdw_flush_inst", id_inst, NOP);
        pcsrc = 1'b0;
        #1;
        chk("rdw_discard_noreq", 32'(req), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = req;
        end
        chk("rdw_req_after", 32'(found), 32'd1);
        chk("rdw_addr", addr, 32'h100);

        // Redirect together with stall while the hold buffer is full.
        delay_lo = 1; delay_hi = 1;
        stall = 1'b1;
        repeat (10) step();
        chk("rs_valid_before", 32'(id_valid), 32'd1);
        chk("rs_noreq_hold", 32'(req), 32'd0);
        pcsrc = 1'b1; target = 32'h200;
        step();
        chk("rs_flush_valid", 32'(id_valid), 32'd0);
        chk("rs_flush_inst", id_inst, NOP);
        pcsrc = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            #1;
            found = req;
            if (!found) step();
        end
        chk("rs_req_after", 32'(found), 32'd1);
        chk("rs_addr", addr, 32'h200);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            found = id_valid;
        end
        chk("rs_deliv_found", 32'(found), 32'd1);
        chk("rs_deliv_pc", id_pc, 32'h200);
        stall = 1'b0;

        // Reset in the middle of an outstanding request.
        delay_lo = 3; delay_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = req;
        end
        chk("rw_req_seen", 32'(found), 32'd1);
        step();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rw_req_after", 32'(req), 32'd1);
        chk("rw_addr_after", addr, 32'd0);

        // Randomized traffic against the reference model.
        delay_lo = 1; delay_hi = 3;
        ready_mode = 1;
        rnd_stim = 1'b1;
        idle = 0;
        live_chk = 1'b1;
        n_deliv = 0;
        repeat (3000) step();
        rnd_stim = 1'b0;
        live_chk = 1'b0;
        pcsrc = 1'b0;
        stall = 1'b0;
        chk("rnd_progress", 32'(n_deliv > 200), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
